// File: rtl/gfx_pkg.sv
// gfx_pkg: register map, reset values and FSM encoding for the graphics register front-end
package gfx_pkg;
  localparam int NUM_REGS = 10;
  localparam logic [3:0] ADDR_P1X    = 4'd0;
  localparam logic [3:0] ADDR_P1Y    = 4'd1;
  localparam logic [3:0] ADDR_P2X    = 4'd2;
  localparam logic [3:0] ADDR_P2Y    = 4'd3;
  localparam logic [3:0] ADDR_BX     = 4'd4;
  localparam logic [3:0] ADDR_BY     = 4'd5;
  localparam logic [3:0] ADDR_BZ     = 4'd6;
  localparam logic [3:0] ADDR_S1     = 4'd7;
  localparam logic [3:0] ADDR_S2     = 4'd8;
  localparam logic [3:0] ADDR_STATE  = 4'd9;
  localparam logic [3:0] ADDR_COMMIT = 4'd10;
  localparam logic [15:0] RST_P1X   = 16'd100;
  localparam logic [15:0] RST_P1Y   = 16'd200;
  localparam logic [15:0] RST_P2X   = 16'd350;
  localparam logic [15:0] RST_P2Y   = 16'd250;
  localparam logic [15:0] RST_BX    = 16'd320;
  localparam logic [15:0] RST_BY    = 16'd240;
  localparam logic [15:0] RST_BZ    = 16'd0;
  localparam logic [15:0] RST_S1    = 16'd0;
  localparam logic [15:0] RST_S2    = 16'd0;
  localparam logic [15:0] RST_STATE = 16'd0;
  localparam logic [15:0] RST_VALS [NUM_REGS] = '{RST_P1X, RST_P1Y, RST_P2X, RST_P2Y, RST_BX,
                                                  RST_BY, RST_BZ, RST_S1, RST_S2, RST_STATE};
  localparam logic [18:0] LAST_PIXEL_DEF = 19'h4AFFF;
  typedef enum logic {IDLE, PENDING} state_t;
endpackage

// File: rtl/gfx_reg_ctrl_if.sv
// gfx_reg_ctrl_if: CPU write bus into the graphics register front-end
interface gfx_reg_ctrl_if;
  logic [3:0]  chipselect;
  logic [15:0] databus;
  logic [3:0]  data_address;
  modport master (output chipselect, databus, data_address);
  modport slave  (input chipselect, databus, data_address);
endinterface

// File: rtl/gfx_shadow_reg.sv
// gfx_shadow_reg: one 16-bit shadow/live register pair; commit copies the pre-write shadow
module gfx_shadow_reg #(
  parameter logic [15:0] RST_VAL = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] wdata,
  input  logic        commit,
  output logic [15:0] live
);
  logic [15:0] shadow;
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RST_VAL;
      live   <= RST_VAL;
    end else begin
      if (commit) live <= shadow;
      if (we) shadow <= wdata;
    end
  end
endmodule

// File: rtl/gfx_reg_ctrl.sv
// gfx_reg_ctrl: shadow register file with end-of-frame atomic commit to the live scene registers
module gfx_reg_ctrl
  import gfx_pkg::*;
#(
  parameter logic [3:0]  CS_ID      = 4'h1,
  parameter logic [18:0] LAST_PIXEL = LAST_PIXEL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  gfx_reg_ctrl_if.slave      bus,
  input  logic               VGA_ready,
  input  logic [18:0]        pixel_address,
  output logic [15:0]        paddle_1_x,
  output logic [15:0]        paddle_1_y,
  output logic [15:0]        paddle_2_x,
  output logic [15:0]        paddle_2_y,
  output logic [15:0]        ball_x,
  output logic [15:0]        ball_y,
  output logic [15:0]        ball_z,
  output logic [15:0]        player_1_score,
  output logic [15:0]        player_2_score,
  output logic [15:0]        game_state,
  output logic               commit_pending,
  output logic               frame_strobe,
  output logic [15:0]        frame_count
);
  state_t      state;
  logic        wr, frame_end, commit;
  logic [15:0] live [NUM_REGS];
  assign wr        = bus.chipselect == CS_ID;
  assign frame_end = VGA_ready && pixel_address == LAST_PIXEL;
  assign commit    = state == PENDING && frame_end;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    gfx_shadow_reg #(.RST_VAL(RST_VALS[i])) u_reg (
      .clk    (clk),
      .rst    (rst),
      .we     (wr && bus.data_address == 4'(i)),
      .wdata  (bus.databus),
      .commit (commit),
      .live   (live[i])
    );
  end
  assign paddle_1_x     = live[ADDR_P1X];
  assign paddle_1_y     = live[ADDR_P1Y];
  assign paddle_2_x     = live[ADDR_P2X];
  assign paddle_2_y     = live[ADDR_P2Y];
  assign ball_x         = live[ADDR_BX];
  assign ball_y         = live[ADDR_BY];
  assign ball_z         = live[ADDR_BZ];
  assign player_1_score = live[ADDR_S1];
  assign player_2_score = live[ADDR_S2];
  assign game_state     = live[ADDR_STATE];
  // A commit request seen in IDLE always waits for the next frame end, even if one is present now
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      commit_pending <= 1'b0;
      frame_strobe   <= 1'b0;
      frame_count    <= 16'd0;
    end else begin
      frame_strobe <= commit;
      frame_count  <= frame_count + 16'(frame_end);
      if (state == IDLE && wr && bus.data_address == ADDR_COMMIT) begin
        state          <= PENDING;
        commit_pending <= 1'b1;
      end else if (commit) begin
        state          <= IDLE;
        commit_pending <= 1'b0;
      end
    end
  end
endmodule
